pea_result_drain: RTL and testbench
===================================

Name: pea_result_drain

Overview:
Consumer side of the PEA output path: drains the paired result and status FIFOs that PEA_top_module_1 fills with a common wr_out. Each entry pair is popped in lock-step and presented to a downstream sink over a valid/ready handshake, tagged with a running index. A flush mode discards pairs instead of presenting them. Population mismatches between the two FIFOs are flagged sticky.

Parameters:
WIDTH, 32, data width of result/status FIFO entries
POP_W, 5, width of FIFO population inputs (log2 of buffer_size_out = 32)
CNT_W, 16, width of out_index and drop_count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
drain_en  input  1  permit starting a new pop sequence
flush  input  1  sampled in IDLE; when 1, the popped pair is discarded
result_pop  input  POP_W  result FIFO population
status_pop  input  POP_W  status FIFO population
result_dout  input  WIDTH  result FIFO read data, valid the cycle after rd_en_result
status_dout  input  WIDTH  status FIFO read data, valid the cycle after rd_en_status
rd_en_result  output  1  result FIFO pop strobe
rd_en_status  output  1  status FIFO pop strobe
out_valid  output  1  pair available to sink
out_ready  input  1  sink accepts pair
out_result  output  WIDTH  captured result word
out_status  output  WIDTH  captured status word
out_index  output  CNT_W  sequence number of presented pair
drop_count  output  CNT_W  number of flushed pairs
err_mismatch  output  1  sticky: populations differed while IDLE
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; rd_en_*, out_valid, err_mismatch = 0; out_result, out_status, out_index, drop_count = 0. Reset mid-sequence abandons any popped-but-unpresented pair.
- States: IDLE, READ, CAPTURE, PRESENT. Moore outputs, all registered.
- IDLE: if drain_en && result_pop!=0 && status_pop!=0 && result_pop==status_pop -> READ; latch flush into drop_mode. Otherwise stay IDLE.
- IDLE, result_pop != status_pop: err_mismatch <= 1 (sticky until rst); no pop issued.
- READ (exactly one cycle): rd_en_result = rd_en_status = 1 -> CAPTURE.
- CAPTURE: out_result <= result_dout, out_status <= status_dout. drop_mode=0 -> PRESENT; drop_mode=1 -> drop_count += 1, -> IDLE, out_* registers not updated.
- PRESENT: out_valid = 1; out_result/out_status/out_index stable while out_valid && !out_ready. On out_valid && out_ready: out_index += 1, -> IDLE, out_valid = 0 next cycle.
- Latency: IDLE qualifying edge n -> rd_en high cycle n+1 -> capture edge n+2 -> out_valid high from cycle n+3. Minimum 4 cycles per presented pair, 3 per dropped pair.
- drain_en and flush only act in IDLE; deasserting mid-sequence never aborts an in-flight pair.
- Exactly one pop per FIFO per sequence; never pops when either population is 0 (no underflow).
- out_index and drop_count wrap modulo 2^CNT_W without saturation or flagging.
- out_ready held high with no pending pair has no effect.

Decomposition:
- Package pea_drain_pkg: state encoding (IDLE=2'd0, READ=2'd1, CAPTURE=2'd2, PRESENT=2'd3), default WIDTH/POP_W/CNT_W constants.
- Single module; no sub-module. The FIFOs are the existing fifo module, instantiated by the surrounding top or bench, not inside this block.

Test Plan:
- Write result 0x0000_0011 / status 0x0000_0001 into both FIFOs, drain_en=1, out_ready=1 -> rd_en pulse for one cycle, out_valid 3 cycles after the qualifying edge with out_result=0x11, out_status=0x1, out_index=0, then index 1, pops return to 0.
- Three pairs loaded, out_ready=0 for 5 cycles then 1 -> first pair held stable for all stalled cycles, no further rd_en until accepted, then pairs delivered in order with out_index 0,1,2.
- flush=1 with two pairs loaded -> no out_valid, drop_count=2, both FIFOs empty, out_index stays 0.
- result_pop=1, status_pop=0 -> no rd_en, err_mismatch=1; populations later equal at 1 -> pair drains normally, err_mismatch stays 1 until rst.
- rst asserted in the CAPTURE cycle -> next cycle state IDLE, out_valid=0, counters 0; remaining FIFO entries drain normally afterwards.
- drain_en=0 with pairs present -> no rd_en; drain_en dropped during READ -> that pair still completes presentation.

Source files
------------

// File: rtl/pea_drain_pkg.sv
// Shared definitions for the PEA result/status drain: state encoding and
// default widths for the FIFO entries, populations and counters.
package pea_drain_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int POP_W_DEF = 5;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } drain_state_t;

endpackage

// File: rtl/pea_result_drain.sv
// Drains the paired result/status FIFOs in lock-step, one entry pair per
// sequence, and hands each pair to a downstream sink over valid/ready with a
// running index. In flush mode the pair is popped and discarded instead.
// Population disagreement seen while idle raises a sticky error flag.
module pea_result_drain
    import pea_drain_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int POP_W = POP_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             flush,
    input  logic [POP_W-1:0] result_pop,
    input  logic [POP_W-1:0] status_pop,
    input  logic [WIDTH-1:0] result_dout,
    input  logic [WIDTH-1:0] status_dout,
    output logic             rd_en_result,
    output logic             rd_en_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_status,
    output logic [CNT_W-1:0] out_index,
    output logic [CNT_W-1:0] drop_count,
    output logic             err_mismatch,
    output logic             busy
);

    localparam logic [POP_W-1:0] POP_ZERO = {POP_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    drain_state_t state_r;
    logic         drop_mode_r;
    logic         mismatch_s;
    logic         qualify_s;

    // Decide whether the FIFO populations allow a safe lock-step pop.
    always_comb begin
        mismatch_s = 1'b0;
        qualify_s  = 1'b0;
        if (result_pop != status_pop) begin
            mismatch_s = 1'b1;
        end else begin
            mismatch_s = 1'b0;
        end
        if (drain_en && (result_pop != POP_ZERO) && !mismatch_s) begin
            qualify_s = 1'b1;
        end else begin
            qualify_s = 1'b0;
        end
    end

    // Sequence FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            drop_mode_r  <= 1'b0;
            rd_en_result <= 1'b0;
            rd_en_status <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= DATA_ZERO;
            out_status   <= DATA_ZERO;
            out_index    <= CNT_ZERO;
            drop_count   <= CNT_ZERO;
            err_mismatch <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mismatch_s) begin
                        err_mismatch <= 1'b1;
                    end
                    if (qualify_s) begin
                        state_r      <= READ;
                        drop_mode_r  <= flush;
                        rd_en_result <= 1'b1;
                        rd_en_status <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                READ: begin
                    // Pop strobes last exactly one cycle per sequence.
                    rd_en_result <= 1'b0;
                    rd_en_status <= 1'b0;
                    state_r      <= CAPTURE;
                end
                CAPTURE: begin
                    // FIFO read data is valid now, one cycle after the pop.
                    if (drop_mode_r) begin
                        drop_count <= drop_count + CNT_ONE;
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        out_result <= result_dout;
                        out_status <= status_dout;
                        out_valid  <= 1'b1;
                        state_r    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_index <= out_index + CNT_ONE;
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        state_r <= PRESENT;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    rd_en_result <= 1'b0;
                    rd_en_status <= 1'b0;
                    out_valid    <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pea_result_drain.sv
// Bench for pea_result_drain: behavioural FIFO pair plus a transaction-level
// expectation queue of pairs that must reach the sink in order.
module tb_pea_result_drain;

    localparam int WIDTH = 32;
    localparam int POP_W = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             drain_en;
    logic             flush;
    logic [POP_W-1:0] result_pop;
    logic [POP_W-1:0] status_pop;
    logic [WIDTH-1:0] result_dout;
    logic [WIDTH-1:0] status_dout;
    logic             rd_en_result;
    logic             rd_en_status;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_status;
    logic [CNT_W-1:0] out_index;
    logic [CNT_W-1:0] drop_count;
    logic             err_mismatch;
    logic             busy;

    pea_result_drain #(.WIDTH(WIDTH), .POP_W(POP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .drain_en(drain_en), .flush(flush),
        .result_pop(result_pop), .status_pop(status_pop),
        .result_dout(result_dout), .status_dout(status_dout),
        .rd_en_result(rd_en_result), .rd_en_status(rd_en_status),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_status(out_status),
        .out_index(out_index), .drop_count(drop_count),
        .err_mismatch(err_mismatch), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rq[$];
    logic [31:0] sq[$];
    logic [63:0] pend[$];
    logic [15:0] exp_index;
    logic [15:0] exp_drop;
    logic        exp_err;
    logic        last_flush;
    logic        pop_is_drop;
    logic        hs_last;
    int          since_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd_pop();
        result_pop = POP_W'(rq.size());
        status_pop = POP_W'(sq.size());
    endtask

    task automatic push_pair(input logic [31:0] r, input logic [31:0] s);
        rq.push_back(r);
        sq.push_back(s);
        upd_pop();
    endtask

    // One clock: FIFO model reacts to the edge, model bookkeeping, then
    // per-cycle checks at the falling edge.
    task automatic tick();
        logic rd_r, rd_s, hs, rst_e, cur_drop;
        rd_r  = (rd_en_result === 1'b1);
        rd_s  = (rd_en_status === 1'b1);
        hs    = (out_valid === 1'b1) && out_ready;
        rst_e = rst;
        cur_drop   = last_flush;
        last_flush = flush;
        @(posedge clk);
        #1;
        if (rd_r) begin
            chk("result_underflow", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) result_dout = rq.pop_front();
        end
        if (rd_s) begin
            chk("status_underflow", 32'(sq.size() > 0), 32'd1);
            if (sq.size() > 0) status_dout = sq.pop_front();
        end
        upd_pop();
        hs_last = 1'b0;
        if (since_pop >= 0) since_pop++;
        if (since_pop > 6) since_pop = -1;
        if (rst_e) begin
            pend.delete();
            exp_index = 16'd0;
            exp_drop  = 16'd0;
            exp_err   = 1'b0;
            since_pop = -1;
        end else begin
            if (hs) begin
                hs_last = 1'b1;
                if (pend.size() > 0) void'(pend.pop_front());
                exp_index = exp_index + 16'd1;
            end
            if (rd_r) begin
                since_pop   = 0;
                pop_is_drop = cur_drop;
                if (cur_drop) exp_drop = exp_drop + 16'd1;
                else pend.push_back({result_dout, status_dout});
            end
        end
        @(negedge clk);
        if (since_pop == 0) begin
            chk("rd_result_one_cycle", 32'(rd_en_result), 32'd0);
            chk("rd_status_one_cycle", 32'(rd_en_status), 32'd0);
        end
        if (since_pop == 1) chk("valid_after_capture", 32'(out_valid), 32'(!pop_is_drop));
        if (hs_last) chk("valid_low_after_accept", 32'(out_valid), 32'd0);
        if (out_valid === 1'b1) begin
            chk("valid_has_pair", 32'(pend.size() > 0), 32'd1);
            chk("rd_while_present", 32'(rd_en_result), 32'd0);
            if (pend.size() > 0) begin
                chk("out_result", out_result, pend[0][63:32]);
                chk("out_status", out_status, pend[0][31:0]);
                chk("out_index", 32'(out_index), 32'(exp_index));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rd_en", 32'({rd_en_result, rd_en_status}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_err", 32'(err_mismatch), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_status", out_status, 32'd0);
    endtask

    task automatic drain_all(input string tag);
        int n;
        n = 0;
        while ((rq.size() != 0 || pend.size() != 0 || busy !== 1'b0) && n < 400) begin
            tick();
            n++;
        end
        tick();
        chk({tag, "_drained"}, 32'(rq.size() + sq.size() + pend.size()), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_index"}, 32'(out_index), 32'(exp_index));
        chk({tag, "_drops"}, 32'(drop_count), 32'(exp_drop));
        chk({tag, "_err"}, 32'(err_mismatch), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1; drain_en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        result_dout = 32'd0; status_dout = 32'd0;
        exp_index = 16'd0; exp_drop = 16'd0; exp_err = 1'b0;
        last_flush = 1'b0; pop_is_drop = 1'b0; hs_last = 1'b0; since_pop = -1;
        upd_pop();
        do_reset();

        // Single pair: strobe after the qualifying edge, valid two edges later.
        push_pair(32'h0000_0011, 32'h0000_0001);
        drain_en = 1'b1; out_ready = 1'b1;
        tick();
        chk("t1_rd_en_result", 32'(rd_en_result), 32'd1);
        chk("t1_rd_en_status", 32'(rd_en_status), 32'd1);
        tick();
        chk("t1_capture_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'h0000_0011);
        chk("t1_status", out_status, 32'h0000_0001);
        chk("t1_index0", 32'(out_index), 32'd0);
        tick();
        chk("t1_index1", 32'(out_index), 32'd1);
        chk("t1_pops_empty", 32'({result_pop, status_pop}), 32'd0);
        drain_all("t1");

        // Back-pressure: first pair held while stalled, then in-order delivery.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_pair($urandom, $urandom);
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stalled_valid", 32'(out_valid), 32'd1);
            chk("t2_no_pop", 32'(rd_en_result | rd_en_status), 32'd0);
        end
        out_ready = 1'b1;
        drain_all("t2");
        chk("t2_three_delivered", 32'(out_index), 32'd3);

        // Flush: two pairs popped and discarded.
        flush = 1'b1;
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        drain_all("t3");
        chk("t3_drop_count", 32'(drop_count), 32'd2);
        flush = 1'b0;

        // Population mismatch: no pop, sticky flag survives a later drain.
        rq.push_back(32'hA5A5_0001);
        upd_pop();
        exp_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_no_pop", 32'(rd_en_result | rd_en_status), 32'd0);
        end
        chk("t4_err_set", 32'(err_mismatch), 32'd1);
        sq.push_back(32'h5A5A_0001);
        upd_pop();
        drain_all("t4");

        // Reset while the popped pair sits in CAPTURE: that pair is lost.
        push_pair(32'hDEAD_0001, 32'hBEEF_0001);
        push_pair(32'hDEAD_0002, 32'hBEEF_0002);
        tick();
        chk("t5_rd_en", 32'(rd_en_result), 32'd1);
        tick();
        do_reset();
        drain_all("t5");
        chk("t5_one_left", 32'(out_index), 32'd1);

        // drain_en low blocks pops; dropping it mid-sequence does not abort.
        drain_en = 1'b0;
        push_pair($urandom, $urandom);
        push_pair($urandom, $urandom);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_gated", 32'(rd_en_result | rd_en_status), 32'd0);
        end
        drain_en = 1'b1;
        tick();
        chk("t6_rd_en", 32'(rd_en_result), 32'd1);
        drain_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_inflight_done", 32'(pend.size()), 32'd0);
        chk("t6_one_remaining", 32'(rq.size()), 32'd1);
        chk("t6_index", 32'(out_index), 32'd2);
        drain_en = 1'b1;
        drain_all("t6");

        // Randomized traffic, stalls, gating and flushes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0 && rq.size() < 20) begin
                push_pair($urandom, $urandom);
                if ($urandom_range(1) == 1) push_pair($urandom, $urandom);
            end
            out_ready = ($urandom_range(9) < 6);
            drain_en  = ($urandom_range(7) != 0);
            flush     = ($urandom_range(3) == 0);
            tick();
        end
        flush = 1'b0; drain_en = 1'b1; out_ready = 1'b1;
        drain_all("t7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
